// File: rtl/nrisc_pc_stack.sv
// rtl/nrisc_pc_stack.sv - NRISC program counter with hardware return-address stack
module nrisc_pc_stack #(
  parameter int PC_WIDTH = 16,
  parameter int STACK_DEPTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [1:0]                     PC_ctrl,
  input  logic                           PC_en,
  input  logic [PC_WIDTH-1:0]            PC_target,
  output logic [PC_WIDTH-1:0]            PC_out,
  output logic [PC_WIDTH-1:0]            STACK_top,
  output logic [$clog2(STACK_DEPTH):0]   STACK_count,
  output logic                           STACK_full,
  output logic                           STACK_empty,
  output logic                           STACK_ovf,
  output logic                           STACK_udf,
  input  logic                           STACK_err_clr
);

  localparam int AW = $clog2(STACK_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    CMD_INC  = 2'd0,
    CMD_JMP  = 2'd1,
    CMD_CALL = 2'd2,
    CMD_RET  = 2'd3
  } pc_cmd_t;

  logic [PC_WIDTH-1:0] mem [STACK_DEPTH];
  logic [PC_WIDTH-1:0] pc_inc;
  logic [CW-1:0]       cnt_m1;
  logic                do_push;
  pc_cmd_t             cmd;

  assign cmd         = pc_cmd_t'(PC_ctrl);
  assign pc_inc      = PC_out + 1'b1;
  assign cnt_m1      = STACK_count - 1'b1;
  assign STACK_full  = (STACK_count == CW'(STACK_DEPTH));
  assign STACK_empty = (STACK_count == '0);
  assign STACK_top   = STACK_empty ? '0 : mem[cnt_m1[AW-1:0]];
  assign do_push     = PC_en && !rst && (cmd == CMD_CALL) && !STACK_full;

  // Storage has no reset; only entries below count are ever observed.
  always_ff @(posedge clk) begin
    if (do_push)
      mem[STACK_count[AW-1:0]] <= pc_inc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      PC_out      <= RESET_VECTOR;
      STACK_count <= '0;
      STACK_ovf   <= 1'b0;
      STACK_udf   <= 1'b0;
    end else begin
      if (STACK_err_clr) begin
        STACK_ovf <= 1'b0;
        STACK_udf <= 1'b0;
      end
      // Flag sets come after the clear so a same-cycle error wins.
      if (PC_en) begin
        case (cmd)
          CMD_INC: PC_out <= pc_inc;
          CMD_JMP: PC_out <= PC_target;
          CMD_CALL: begin
            if (STACK_full) begin
              PC_out    <= pc_inc;
              STACK_ovf <= 1'b1;
            end else begin
              PC_out      <= PC_target;
              STACK_count <= STACK_count + 1'b1;
            end
          end
          CMD_RET: begin
            if (STACK_empty) begin
              PC_out    <= pc_inc;
              STACK_udf <= 1'b1;
            end else begin
              PC_out      <= mem[cnt_m1[AW-1:0]];
              STACK_count <= cnt_m1;
            end
          end
          default: PC_out <= PC_out;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nrisc_pc_stack.sv
// tb/tb_nrisc_pc_stack.sv - directed self-checking bench for nrisc_pc_stack
module tb_nrisc_pc_stack;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  PC_ctrl;
  logic        PC_en;
  logic [15:0] PC_target;
  logic [15:0] PC_out;
  logic [15:0] STACK_top;
  logic [3:0]  STACK_count;
  logic        STACK_full;
  logic        STACK_empty;
  logic        STACK_ovf;
  logic        STACK_udf;
  logic        STACK_err_clr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nrisc_pc_stack #(.PC_WIDTH(16), .STACK_DEPTH(8), .RESET_VECTOR(16'h0000)) dut (
    .clk(clk), .rst(rst), .PC_ctrl(PC_ctrl), .PC_en(PC_en), .PC_target(PC_target),
    .PC_out(PC_out), .STACK_top(STACK_top), .STACK_count(STACK_count),
    .STACK_full(STACK_full), .STACK_empty(STACK_empty), .STACK_ovf(STACK_ovf),
    .STACK_udf(STACK_udf), .STACK_err_clr(STACK_err_clr)
  );

  task automatic step(input logic [1:0] c, input logic e, input logic [15:0] t,
                      input logic clr, input logic r);
    PC_ctrl = c; PC_en = e; PC_target = t; STACK_err_clr = clr; rst = r;
    @(posedge clk);
    #1;
    PC_en = 1'b0; STACK_err_clr = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset;
    step(2'd0, 1'b0, 16'h0, 1'b0, 1'b1);
    checks++;
    if (PC_out !== 16'h0000 || STACK_count !== 4'd0 || STACK_empty !== 1'b1 ||
        STACK_full !== 1'b0 || STACK_top !== 16'h0 || STACK_ovf !== 1'b0 || STACK_udf !== 1'b0) begin
      failures++;
      $display("FAIL reset: pc=%h cnt=%0d empty=%b full=%b top=%h ovf=%b udf=%b, need 0000 0 1 0 0000 0 0",
               PC_out, STACK_count, STACK_empty, STACK_full, STACK_top, STACK_ovf, STACK_udf);
    end
  endtask

  task automatic test_inc_gaps;
    logic [15:0] exp_pc;
    exp_pc = 16'h0;
    for (int i = 0; i < 6; i++) begin
      logic en;
      en = (i % 2) == 1;
      step(2'd0, en, 16'hDEAD, 1'b0, 1'b0);
      if (en) exp_pc = exp_pc + 16'd1;
      checks++;
      if (PC_out !== exp_pc || STACK_count !== 4'd0 || STACK_empty !== 1'b1) begin
        failures++;
        $display("FAIL inc_gap[%0d]: pc=%h cnt=%0d empty=%b, need pc=%h cnt=0 empty=1",
                 i, PC_out, STACK_count, STACK_empty, exp_pc);
      end
    end
  endtask

  task automatic test_jmp_wrap;
    step(2'd1, 1'b1, 16'h00FF, 1'b0, 1'b0);
    step(2'd1, 1'b1, 16'h1234, 1'b0, 1'b0);
    checks++;
    if (PC_out !== 16'h1234 || STACK_count !== 4'd0) begin
      failures++;
      $display("FAIL jmp: pc=%h cnt=%0d, need 1234 0", PC_out, STACK_count);
    end
    step(2'd1, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    step(2'd0, 1'b1, 16'h0, 1'b0, 1'b0);
    checks++;
    if (PC_out !== 16'h0000 || STACK_ovf !== 1'b0 || STACK_udf !== 1'b0) begin
      failures++;
      $display("FAIL inc_wrap: pc=%h ovf=%b udf=%b, need 0000 0 0", PC_out, STACK_ovf, STACK_udf);
    end
  endtask

  task automatic test_call_ret;
    step(2'd1, 1'b1, 16'h0010, 1'b0, 1'b0);
    step(2'd2, 1'b1, 16'h0200, 1'b0, 1'b0);
    checks++;
    if (PC_out !== 16'h0200 || STACK_count !== 4'd1 || STACK_top !== 16'h0011 || STACK_empty !== 1'b0) begin
      failures++;
      $display("FAIL call: pc=%h cnt=%0d top=%h empty=%b, need 0200 1 0011 0",
               PC_out, STACK_count, STACK_top, STACK_empty);
    end
    step(2'd3, 1'b1, 16'h0, 1'b0, 1'b0);
    checks++;
    if (PC_out !== 16'h0011 || STACK_count !== 4'd0 || STACK_empty !== 1'b1 || STACK_top !== 16'h0) begin
      failures++;
      $display("FAIL ret: pc=%h cnt=%0d empty=%b top=%h, need 0011 0 1 0000",
               PC_out, STACK_count, STACK_empty, STACK_top);
    end
  endtask

  task automatic test_overflow;
    logic [15:0] ret_addr;
    step(2'd1, 1'b1, 16'h0020, 1'b0, 1'b0);
    // Targets 0x0100..0x0700 then 0x0300; pushed returns 0x0021, 0x0101..0x0701.
    for (int i = 0; i < 8; i++) begin
      step(2'd2, 1'b1, (i == 7) ? 16'h0300 : 16'(16'h0100 * (i + 1)), 1'b0, 1'b0);
      ret_addr = (i == 0) ? 16'h0021 : 16'(16'h0100 * i + 1);
      checks++;
      if (STACK_count !== 4'(i + 1) || STACK_top !== ret_addr) begin
        failures++;
        $display("FAIL push[%0d]: cnt=%0d top=%h, need %0d %h", i, STACK_count, STACK_top, i + 1, ret_addr);
      end
    end
    checks++;
    if (STACK_full !== 1'b1 || PC_out !== 16'h0300 || STACK_ovf !== 1'b0) begin
      failures++;
      $display("FAIL full: full=%b pc=%h ovf=%b, need 1 0300 0", STACK_full, PC_out, STACK_ovf);
    end
    step(2'd2, 1'b1, 16'h0500, 1'b0, 1'b0);
    checks++;
    if (PC_out !== 16'h0301 || STACK_count !== 4'd8 || STACK_ovf !== 1'b1 || STACK_top !== 16'h0701) begin
      failures++;
      $display("FAIL ovf_call: pc=%h cnt=%0d ovf=%b top=%h, need 0301 8 1 0701",
               PC_out, STACK_count, STACK_ovf, STACK_top);
    end
    for (int k = 7; k >= 0; k--) begin
      step(2'd3, 1'b1, 16'h0, 1'b0, 1'b0);
      ret_addr = (k == 0) ? 16'h0021 : 16'(16'h0100 * k + 1);
      checks++;
      if (PC_out !== ret_addr || STACK_count !== 4'(k)) begin
        failures++;
        $display("FAIL pop[%0d]: pc=%h cnt=%0d, need %h %0d", k, PC_out, STACK_count, ret_addr, k);
      end
    end
    checks++;
    if (STACK_empty !== 1'b1 || STACK_ovf !== 1'b1 || STACK_udf !== 1'b0) begin
      failures++;
      $display("FAIL drained: empty=%b ovf=%b udf=%b, need 1 1 0", STACK_empty, STACK_ovf, STACK_udf);
    end
    step(2'd0, 1'b0, 16'h0, 1'b1, 1'b0);
    checks++;
    if (STACK_ovf !== 1'b0 || PC_out !== 16'h0021) begin
      failures++;
      $display("FAIL ovf_clr: ovf=%b pc=%h, need 0 0021", STACK_ovf, PC_out);
    end
  endtask

  task automatic test_underflow;
    step(2'd1, 1'b1, 16'h0040, 1'b0, 1'b0);
    step(2'd3, 1'b1, 16'h0, 1'b0, 1'b0);
    checks++;
    if (PC_out !== 16'h0041 || STACK_udf !== 1'b1 || STACK_count !== 4'd0) begin
      failures++;
      $display("FAIL udf: pc=%h udf=%b cnt=%0d, need 0041 1 0", PC_out, STACK_udf, STACK_count);
    end
    step(2'd3, 1'b0, 16'h0, 1'b1, 1'b0);
    checks++;
    if (STACK_udf !== 1'b0 || PC_out !== 16'h0041) begin
      failures++;
      $display("FAIL udf_clr: udf=%b pc=%h, need 0 0041", STACK_udf, PC_out);
    end
    step(2'd3, 1'b1, 16'h0, 1'b1, 1'b0);
    checks++;
    if (STACK_udf !== 1'b1 || PC_out !== 16'h0042) begin
      failures++;
      $display("FAIL udf_set_wins: udf=%b pc=%h, need 1 0042", STACK_udf, PC_out);
    end
  endtask

  task automatic test_reset_mid;
    step(2'd1, 1'b1, 16'h0050, 1'b0, 1'b0);
    step(2'd2, 1'b1, 16'h0060, 1'b0, 1'b0);
    step(2'd2, 1'b1, 16'h0070, 1'b0, 1'b0);
    checks++;
    if (STACK_count !== 4'd2 || STACK_top !== 16'h0061 || STACK_udf !== 1'b1) begin
      failures++;
      $display("FAIL pre_rst: cnt=%0d top=%h udf=%b, need 2 0061 1", STACK_count, STACK_top, STACK_udf);
    end
    step(2'd3, 1'b1, 16'h0, 1'b0, 1'b1);
    checks++;
    if (PC_out !== 16'h0000 || STACK_count !== 4'd0 || STACK_ovf !== 1'b0 ||
        STACK_udf !== 1'b0 || STACK_top !== 16'h0) begin
      failures++;
      $display("FAIL rst_mid: pc=%h cnt=%0d ovf=%b udf=%b top=%h, need 0000 0 0 0 0000",
               PC_out, STACK_count, STACK_ovf, STACK_udf, STACK_top);
    end
    step(2'd3, 1'b1, 16'h0, 1'b0, 1'b0);
    checks++;
    if (STACK_udf !== 1'b1 || PC_out !== 16'h0001 || STACK_count !== 4'd0) begin
      failures++;
      $display("FAIL post_rst_ret: udf=%b pc=%h cnt=%0d, need 1 0001 0", STACK_udf, PC_out, STACK_count);
    end
  endtask

  initial begin
    rst = 1'b1; PC_ctrl = 2'd0; PC_en = 1'b0; PC_target = 16'h0; STACK_err_clr = 1'b0;
    @(posedge clk);
    #1;
    test_reset;
    test_inc_gaps;
    test_jmp_wrap;
    test_call_ret;
    test_overflow;
    test_underflow;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
